// File: rtl/guitar_pkg.sv
// Shared definitions for the guitar_IP effect blocks.
//   ANGLE_W / TRIG_W : fixed-point widths of CORDIC angles and sin/cos results.
//   port_state_e     : per-requester handshake state used by cordic_arbiter.
package guitar_pkg;

  localparam int ANGLE_W = 32;  // fxp 32-29 angle
  localparam int TRIG_W  = 32;  // fxp 32, 24-22 payload

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2,
    DONE     = 2'd3
  } port_state_e;

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO of requester tags, one entry per CORDIC operation in flight.
// Push and pop in the same cycle are both honoured, even when the FIFO is full.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write strobe and tag
//   pop               read strobe; pop_data is the current head (valid when !empty)
//   full, empty       occupancy flags
module tag_fifo #(
  parameter int DEPTH = 4,  // power of 2, >= 2
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same edge, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is left out of reset; pointers and count alone define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC sin/cos core among N_REQ requesters. Requests are granted
// round-robin, the owner tag of every issued angle is queued, and each result
// (returned in issue order) is routed back to its owner.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid[N_REQ]                per-port request level
//   req_angle[32*N_REQ]             per-port angle, port i at [32i+31:32i]
//   resp_valid[N_REQ]               one-cycle result pulse to the owning port
//   resp_sin, resp_cos              registered result, shared by all ports
//   cordic_angle, cordic_angle_valid  issue to the core (no backpressure)
//   cordic_sin, cordic_cos, cordic_out_valid  result from the core
//   busy                            operations outstanding in the core
//   err_orphan                      sticky: result arrived with nothing outstanding
module cordic_arbiter
  import guitar_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4,
  parameter int TAG_W     = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [ANGLE_W*N_REQ-1:0] req_angle,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [TRIG_W-1:0]        resp_sin,
  output logic [TRIG_W-1:0]        resp_cos,
  output logic [ANGLE_W-1:0]       cordic_angle,
  output logic                     cordic_angle_valid,
  input  logic [TRIG_W-1:0]        cordic_sin,
  input  logic [TRIG_W-1:0]        cordic_cos,
  input  logic                     cordic_out_valid,
  output logic                     busy,
  output logic                     err_orphan
);

  port_state_e        st [N_REQ];
  logic [TAG_W-1:0]   rr;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [ANGLE_W-1:0] grant_angle;
  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   elig_rot;
  logic [2*N_REQ-1:0] elig_dbl;
  logic [N_REQ-1:0]   grant_vec;
  logic [N_REQ-1:0]   resp_vec;
  logic [TAG_W-1:0]   head_tag;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign pop  = cordic_out_valid && !fifo_empty;
  assign busy = !fifo_empty;

  // A port raising req_valid while IDLE competes in that same cycle, so a
  // request seen in cycle t is issued in t+1; ungranted it parks in PENDING.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      elig[i] = req_valid[i] && (st[i] == IDLE || st[i] == PENDING);
  end

  // Rotate so bit j of elig_rot is port (rr+1+j) mod N_REQ; the lowest set bit wins.
  // NOTE: every signal driven here gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig_dbl    = {elig, elig} >> (int'(rr) + 1);
    elig_rot    = elig_dbl[N_REQ-1:0];
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (elig_rot[j] && !fifo_full) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_W'((int'(rr) + 1 + j) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_angle = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_vec[i] = grant_valid && (grant_idx == TAG_W'(i));
      resp_vec[i]  = pop && (head_tag == TAG_W'(i));
      if (grant_vec[i]) grant_angle = req_angle[i*ANGLE_W +: ANGLE_W];
    end
  end

  tag_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (grant_idx),
    .pop       (pop),
    .pop_data  (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Per-port handshake FSMs. DONE blocks re-issue until the requester drops
  // req_valid, so a requester that lowers valid a cycle late is not served twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) st[i] <= IDLE;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        unique case (st[i])
          IDLE:     if (req_valid[i]) st[i] <= grant_vec[i] ? INFLIGHT : PENDING;
          PENDING: begin
            if (!req_valid[i])     st[i] <= IDLE;
            else if (grant_vec[i]) st[i] <= INFLIGHT;
          end
          // Dropping req_valid here is ignored: the core result still arrives.
          INFLIGHT: if (resp_vec[i]) st[i] <= DONE;
          DONE:     if (!req_valid[i]) st[i] <= IDLE;
          default:  st[i] <= IDLE;
        endcase
      end
    end
  end

  // Issue and return datapath, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr                 <= '0;
      cordic_angle       <= '0;
      cordic_angle_valid <= 1'b0;
      resp_valid         <= '0;
      resp_sin           <= '0;
      resp_cos           <= '0;
      err_orphan         <= 1'b0;
    end else begin
      cordic_angle_valid <= grant_valid;
      if (grant_valid) begin
        cordic_angle <= grant_angle;
        rr           <= grant_idx;
      end
      resp_valid <= resp_vec;
      if (pop) begin
        resp_sin <= cordic_sin;
        resp_cos <= cordic_cos;
      end
      if (cordic_out_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter with six requesters and four tags.
// The core is modelled by the bench: issued angles are logged in issue order,
// and whenever the bench returns a result it pushes the expected owner and
// sin/cos to a scoreboard that is compared against the next resp_valid pulse.
module tb_cordic_arbiter;

  localparam int NP = 6;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req_valid;
  logic [32*NP-1:0] req_angle;
  logic [NP-1:0]    resp_valid;
  logic [31:0]      resp_sin, resp_cos;
  logic [31:0]      cordic_angle;
  logic             cordic_angle_valid;
  logic [31:0]      cordic_sin, cordic_cos;
  logic             cordic_out_valid;
  logic             busy;
  logic             err_orphan;

  cordic_arbiter #(.N_REQ(NP), .MAX_OUTST(MO)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_angle          (req_angle),
    .resp_valid         (resp_valid),
    .resp_sin           (resp_sin),
    .resp_cos           (resp_cos),
    .cordic_angle       (cordic_angle),
    .cordic_angle_valid (cordic_angle_valid),
    .cordic_sin         (cordic_sin),
    .cordic_cos         (cordic_cos),
    .cordic_out_valid   (cordic_out_valid),
    .busy               (busy),
    .err_orphan         (err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { int port; logic [31:0] ang; } iss_t;
  typedef struct { int port; logic [31:0] s; logic [31:0] c; } exp_t;

  iss_t        iss_q[$];
  exp_t        sb_q[$];
  int          iss_order[$];
  logic [31:0] port_ang [NP];
  bit          port_busy [NP];
  bit          just_dropped [NP];
  bit          auto_drop;
  bit          ret_pending;
  logic [31:0] last_sin;
  int          iss_cnt, resp_total;
  int          n_checks, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a);
    port_ang[i]            = a;
    req_angle[i*32 +: 32]  = a;
    req_valid[i]           = 1'b1;
  endtask

  // Core model: return the oldest issued angle with the given sin/cos.
  task automatic core_ret(input logic [31:0] s, input logic [31:0] c);
    iss_t it;
    it = iss_q.pop_front();
    cordic_out_valid = 1'b1;
    cordic_sin       = s;
    cordic_cos       = c;
    sb_q.push_back('{it.port, s, c});
    last_sin    = s;
    ret_pending = 1'b1;
  endtask

  task automatic core_ret_rand();
    core_ret($urandom, $urandom);
  endtask

  task automatic monitor(input bit want);
    int   o;
    exp_t e;
    for (int i = 0; i < NP; i++) just_dropped[i] = 1'b0;
    if (cordic_angle_valid) begin
      o = -1;
      for (int i = 0; i < NP; i++)
        if (req_valid[i] && !port_busy[i] && port_ang[i] == cordic_angle) o = i;
      check("issue_owner", (o >= 0), 1);
      if (o >= 0) begin
        port_busy[o] = 1'b1;
        iss_q.push_back('{o, cordic_angle});
      end
      iss_order.push_back(o);
      iss_cnt++;
    end
    if (want || resp_valid != '0) begin
      if (!want || sb_q.size() == 0) begin
        check("resp_unexpected", resp_valid, 0);
      end else begin
        e = sb_q.pop_front();
        check("resp_port", resp_valid, NP'(1) << e.port);
        check("resp_sin", resp_sin, e.s);
        check("resp_cos", resp_cos, e.c);
        port_busy[e.port] = 1'b0;
        resp_total++;
        if (auto_drop) begin
          req_valid[e.port]    = 1'b0;
          just_dropped[e.port] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    bit want;
    @(posedge clk);
    #1;
    want             = ret_pending;
    ret_pending      = 1'b0;
    cordic_out_valid = 1'b0;
    monitor(want);
  endtask

  initial begin
    int n0, ord0, busy_low, made, r0;
    rst = 1'b1; req_valid = '0; req_angle = '0;
    cordic_out_valid = 1'b0; cordic_sin = '0; cordic_cos = '0;
    auto_drop = 1'b0; ret_pending = 1'b0; last_sin = '0;
    iss_cnt = 0; resp_total = 0; n_checks = 0; n_err = 0;
    for (int i = 0; i < NP; i++) begin
      port_ang[i] = '0; port_busy[i] = 1'b0; just_dropped[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {resp_valid, cordic_angle_valid, busy, err_orphan}, 0);
    check("rst_res", {resp_sin, resp_cos}, 0);
    check("rst_ang", cordic_angle, 0);
    rst = 1'b0;
    step();

    // Single request, held one cycle past its response
    n0 = iss_cnt;
    set_req(0, 32'h00022508);
    step();
    check("t1_iss_vld", cordic_angle_valid, 1);
    check("t1_iss_ang", cordic_angle, 32'h00022508);
    check("t1_busy", busy, 1);
    repeat (3) step();
    core_ret(32'h00000890, 32'h00400000);
    step();
    check("t1_resp_vld", resp_valid, 6'b000001);
    step();
    req_valid[0] = 1'b0;
    repeat (3) step();
    check("t1_no_reissue", iss_cnt - n0, 1);
    check("t1_idle", busy, 0);
    check("t1_sin_hold", resp_sin, 32'h00000890);

    // Contention: rr=0, so port1 goes first
    auto_drop = 1'b1;
    set_req(0, 32'h00088420);
    set_req(1, 32'h00110840);
    step();
    check("t2_first", cordic_angle, 32'h00110840);
    step();
    check("t2_second_vld", cordic_angle_valid, 1);
    check("t2_second", cordic_angle, 32'h00088420);
    core_ret_rand();
    step();
    check("t2_resp1", resp_valid, 6'b000010);
    core_ret_rand();
    step();
    check("t2_resp0", resp_valid, 6'b000001);
    repeat (2) step();

    // Back-pressure: six requests, four tags
    n0 = iss_cnt; ord0 = iss_order.size();
    for (int i = 0; i < NP; i++) set_req(i, 32'h1000_0000 + 32'(i) * 32'h111);
    repeat (8) step();
    check("t3_cap", iss_cnt - n0, 4);
    for (int k = 0; k < 4; k++) check("t3_order", iss_order[ord0 + k], k + 1);
    check("t3_busy", busy, 1);
    core_ret_rand();
    step();
    check("t3_wait", iss_cnt - n0, 4);
    step();
    check("t3_one_more", iss_cnt - n0, 5);
    check("t3_order4", iss_order[ord0 + 4], 5);
    repeat (4) step();
    check("t3_full_again", iss_cnt - n0, 5);
    busy_low = 0;
    for (int k = 0; k < 60 && (iss_q.size() > 0 || req_valid != '0); k++) begin
      if (iss_q.size() > 0) begin
        busy_low += int'(!busy);
        core_ret_rand();
      end
      step();
    end
    check("t3_busy_held", busy_low, 0);
    check("t3_total", iss_cnt - n0, 6);
    check("t3_order5", iss_order[ord0 + 5], 0);
    check("t3_drained", busy, 0);

    // Random traffic with the tag FIFO frequently full
    made = 0; r0 = resp_total;
    for (int cyc = 0; cyc < 3000 && (resp_total - r0) < 20; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (!req_valid[i] && !port_busy[i] && !just_dropped[i] && made < 20 &&
            $urandom_range(0, 2) == 0) begin
          set_req(i, {8'(i), 8'(made), 16'($urandom)});
          made++;
        end
      end
      if (iss_q.size() > 0 && $urandom_range(0, 2) == 0) core_ret_rand();
      step();
    end
    check("t4_all_done", resp_total - r0, 20);
    check("t4_sb_empty", sb_q.size(), 0);
    repeat (2) step();
    check("t4_idle", busy, 0);

    // Orphan result
    cordic_out_valid = 1'b1;
    cordic_sin = 32'hDEAD0001;
    cordic_cos = 32'hDEAD0002;
    step();
    check("orph_no_resp", resp_valid, 0);
    check("orph_err", err_orphan, 1);
    check("orph_sin_hold", resp_sin, last_sin);
    repeat (5) step();
    check("orph_sticky", err_orphan, 1);

    // Reset with two requests in flight
    set_req(0, 32'h0000_1111);
    set_req(1, 32'h0000_2222);
    repeat (3) step();
    check("t6_inflight", busy, 1);
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    check("t6_rst_ctl", {resp_valid, cordic_angle_valid, busy, err_orphan}, 0);
    check("t6_rst_res", {resp_sin, resp_cos, cordic_angle}, 0);
    iss_q.delete(); sb_q.delete();
    for (int i = 0; i < NP; i++) port_busy[i] = 1'b0;
    rst = 1'b0;
    step();
    set_req(0, 32'h0ABC_0123);
    step();
    check("t6_iss_vld", cordic_angle_valid, 1);
    check("t6_iss_ang", cordic_angle, 32'h0ABC_0123);
    step();
    core_ret(32'h1234_5678, 32'h8765_4321);
    step();
    check("t6_resp", resp_valid, 6'b000001);
    check("t6_no_orphan", err_orphan, 0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
